dmux_stream: RTL

- Parametrised 1:N demultiplexer for 16-bit datapath streams: routes one input word per cycle to one of CHANNELS output channels selected by `in_sel`.
- Successor to the fixed 1:2 combinational demux. Adds valid/ready handshakes, a registered one-entry buffer per channel, out-of-range select detection, and an error counter.
- Sits between the CPU datapath and peripheral/memory-mapped sinks.

---
 rtl/dmux_pkg.sv | 22 ++
 rtl/dmux_slot.sv | 49 ++++
 rtl/dmux_stream.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmux_pkg.sv
// dmux_pkg
// Shared definitions for the dmux_stream demultiplexer slice.
//   CHAN_MAX      : largest channel count the demux is meant to be built with
//   DEFAULT_WIDTH : default datapath width in bits
//   word_t        : one 16-bit datapath word
//   sel_in_range  : true when a select value addresses an existing channel
package dmux_pkg;

  localparam int CHAN_MAX      = 16;
  localparam int DEFAULT_WIDTH = 16;

  typedef logic [15:0] word_t;

  // A select is only meaningful when it names a built channel. With a
  // non-power-of-two channel count the select field can encode indices
  // that have no slot behind them.
  function automatic logic sel_in_range(input int unsigned sel,
                                        input int unsigned channels);
    return sel < channels;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// dmux_slot
// One-entry registered output buffer for a single demux channel.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, empties the buffer and zeroes data
//   load      : write load_data into the buffer this cycle (only when can_take)
//   load_data : word to store
//   out_valid : buffer holds a word
//   out_ready : sink takes the held word this cycle
//   out_data  : held word, kept after the word drains
//   can_take  : buffer is empty or is being drained, so a load is safe
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             can_take
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain so that a word leaving and a word arriving
  // in the same cycle keep the buffer full; this is what lets a
  // continuously ready sink run at one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign can_take  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/dmux_stream.sv
// dmux_stream
// Parametrised 1:N stream demultiplexer with valid/ready handshakes, one
// registered buffer per channel, out-of-range select detection and a
// saturating drop counter.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   in_valid   : input word present
//   in_ready   : input word accepted this cycle when in_valid && in_ready
//   in_data    : input word
//   in_sel     : destination channel index
//   in_bcast   : (DMUX_BCAST_EN builds only) load the word into every channel
//   out_valid  : per-channel word present
//   out_ready  : per-channel sink ready
//   out_data   : packed, channel k at [k*WIDTH +: WIDTH]
//   err_pulse  : one-cycle pulse after an out-of-range word is dropped
//   err_cnt    : saturating count of dropped words
// Build option: define DMUX_BCAST_EN to add the in_bcast port. Without it
// the design behaves as if in_bcast were tied low.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int CHANNELS = 4,
  parameter  int ERR_W    = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
`ifdef DMUX_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err_pulse,
  output logic [ERR_W-1:0]          err_cnt
);

  logic                w_bcast;
  logic                w_selInRange;
  logic                w_selReady;
  logic                w_accept;
  logic                w_drop;
  logic [CHANNELS-1:0] w_selHit;
  logic [CHANNELS-1:0] w_canTake;
  logic [CHANNELS-1:0] w_load;
  logic                r_errPulse;
  logic [ERR_W-1:0]    r_errCnt;

`ifdef DMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_selInRange = sel_in_range(32'(in_sel), 32'(CHANNELS));

  // Decode the select into a one-hot channel hit and pick that channel's
  // readiness. A select with no channel behind it matches nothing, leaves
  // the ready at 1 and so is always accepted (and then dropped).
  always_comb begin
    w_selReady = 1'b1;
    w_selHit   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_selReady  = w_canTake[k];
        w_selHit[k] = 1'b1;
      end
    end
  end

  // A broadcast must land in every channel at once, so it waits until all
  // of them can take a word.
  assign in_ready = w_bcast ? (&w_canTake) : w_selReady;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept ? (w_bcast ? {CHANNELS{1'b1}} : w_selHit)
                             : {CHANNELS{1'b0}};
  assign w_drop   = w_accept && !w_bcast && !w_selInRange;

  for (genvar k = 0; k < CHANNELS; k++) begin : gSlot
    dmux_slot #(
      .WIDTH(WIDTH)
    ) uSlot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load[k]),
      .load_data(in_data),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .out_data (out_data[k*WIDTH +: WIDTH]),
      .can_take (w_canTake[k])
    );
  end

  // Dropped words raise a single-cycle pulse and bump a counter that
  // sticks at all-ones instead of wrapping back to a small value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_errPulse <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      r_errPulse <= w_drop;
      if (w_drop && (r_errCnt != {ERR_W{1'b1}})) begin
        r_errCnt <= r_errCnt + ERR_W'(1);
      end
    end
  end

  assign err_pulse = r_errPulse;
  assign err_cnt   = r_errCnt;

endmodule
